// File: rtl/synapse_weight_bank_if.sv
// rtl/synapse_weight_bank_if.sv - bus bundle for the synaptic weight bank
// Ports (slave view): kill; load_valid/load_data/load_ready/load_done;
// rd_valid/rd_addr/rd_ready/rd_out_valid/weight_out;
// stdp_valid/stdp_addr/stdp_delta/stdp_ready; addr_err; sat_count.
interface synapse_weight_bank_if #(
    parameter int W_BITS  = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DELTA_W = 8
) ();
    logic               kill;
    logic               load_valid;
    logic [DATA_W-1:0]  load_data;
    logic               load_ready;
    logic               load_done;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ready;
    logic               rd_out_valid;
    logic [W_BITS-1:0]  weight_out;
    logic               stdp_valid;
    logic [ADDR_W-1:0]  stdp_addr;
    logic [DELTA_W-1:0] stdp_delta;
    logic               stdp_ready;
    logic               addr_err;
    logic [15:0]        sat_count;

    modport master (
        output kill, load_valid, load_data, rd_valid, rd_addr,
               stdp_valid, stdp_addr, stdp_delta,
        input  load_ready, load_done, rd_ready, rd_out_valid, weight_out,
               stdp_ready, addr_err, sat_count
    );

    modport slave (
        input  kill, load_valid, load_data, rd_valid, rd_addr,
               stdp_valid, stdp_addr, stdp_delta,
        output load_ready, load_done, rd_ready, rd_out_valid, weight_out,
               stdp_ready, addr_err, sat_count
    );
endinterface

// File: rtl/synapse_weight_bank.sv
// rtl/synapse_weight_bank.sv - packed synaptic weight store with bulk load, reads and STDP updates
// Ports: clk, rst (async, active-low), bus (synapse_weight_bank_if.slave).
// Bulk-load phase fills DEPTH words, then run phase serves single-weight
// reads and saturating STDP read-modify-writes.
module synapse_weight_bank #(
    parameter int W_BITS  = 8,
    parameter int DATA_W  = 32,
    parameter int N_SYN   = 128,
    parameter int ADDR_W  = 16,
    parameter int DELTA_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    synapse_weight_bank_if.slave bus
);
    localparam int PER_WORD = DATA_W / W_BITS;
    localparam int DEPTH    = N_SYN / PER_WORD;
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W   = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;
    // Two guard bits: one for overflow above the max weight, one for sign.
    localparam int SUM_W    = W_BITS + 2;
    localparam logic [ADDR_W:0]   N_SYN_A    = (ADDR_W + 1)'(N_SYN);
    localparam logic [ADDR_W-1:0] PER_WORD_A = ADDR_W'(PER_WORD);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_RMW_RD, S_RMW_WR} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                load_ready_q;
    logic                load_done_q;
    logic                rd_out_valid_q;
    logic [W_BITS-1:0]   weight_out_q;
    logic                addr_err_q;
    logic [15:0]         sat_count_q;
    logic [PTR_W-1:0]    rmw_widx_q;
    logic [LANE_W-1:0]   rmw_lane_q;
    logic [DELTA_W-1:0]  rmw_delta_q;
    logic [DATA_W-1:0]   rmw_word_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                rd_inr;
    logic                st_inr;
    logic [PTR_W-1:0]    rd_widx;
    logic [LANE_W-1:0]   rd_lane;
    logic [DATA_W-1:0]   rd_word;
    logic [W_BITS-1:0]   rd_weight;
    logic [W_BITS-1:0]   old_w;
    logic [SUM_W-1:0]    delta_ext;
    logic [SUM_W-1:0]    sum;
    logic [W_BITS-1:0]   new_w;
    logic                sat;
    logic [DATA_W-1:0]   new_word;
    logic                mem_we;
    logic [PTR_W-1:0]    mem_widx;
    logic [DATA_W-1:0]   mem_wdata;

    always_comb begin
        run       = (state_q == S_RUN);
        rd_inr    = {1'b0, bus.rd_addr} < N_SYN_A;
        st_inr    = {1'b0, bus.stdp_addr} < N_SYN_A;
        rd_widx   = PTR_W'(bus.rd_addr / PER_WORD_A);
        rd_lane   = LANE_W'(bus.rd_addr % PER_WORD_A);
        rd_word   = mem_q[rd_widx];
        rd_weight = rd_word[rd_lane*W_BITS +: W_BITS];

        // Saturating add: negative results clamp to 0, overflow to all-ones.
        old_w     = rmw_word_q[rmw_lane_q*W_BITS +: W_BITS];
        delta_ext = SUM_W'($signed(rmw_delta_q));
        sum       = {2'b00, old_w} + delta_ext;
        sat       = 1'b0;
        new_w     = sum[W_BITS-1:0];
        if (sum[SUM_W-1]) begin
            new_w = '0;
            sat   = 1'b1;
        end else if (sum[W_BITS]) begin
            new_w = '1;
            sat   = 1'b1;
        end
        new_word = rmw_word_q;
        new_word[rmw_lane_q*W_BITS +: W_BITS] = new_w;

        // kill and reset both abandon any pending write.
        mem_we    = rst && !bus.kill &&
                    ((state_q == S_LOAD && bus.load_valid) || state_q == S_RMW_WR);
        mem_widx  = (state_q == S_LOAD) ? ptr_q : rmw_widx_q;
        mem_wdata = (state_q == S_LOAD) ? bus.load_data : new_word;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_LOAD;
            ptr_q          <= '0;
            load_ready_q   <= 1'b1;
            load_done_q    <= 1'b0;
            rd_out_valid_q <= 1'b0;
            weight_out_q   <= '0;
            addr_err_q     <= 1'b0;
            sat_count_q    <= '0;
            rmw_widx_q     <= '0;
            rmw_lane_q     <= '0;
            rmw_delta_q    <= '0;
            rmw_word_q     <= '0;
        end else begin
            rd_out_valid_q <= 1'b0;
            addr_err_q     <= 1'b0;
            if (bus.kill) begin
                state_q      <= S_LOAD;
                ptr_q        <= '0;
                load_ready_q <= 1'b1;
                load_done_q  <= 1'b0;
                sat_count_q  <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (bus.load_valid) begin
                            ptr_q <= ptr_q + 1'b1;
                            if (ptr_q == LAST_PTR) begin
                                ptr_q        <= '0;
                                state_q      <= S_RUN;
                                load_ready_q <= 1'b0;
                                load_done_q  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        // A read takes priority; a competing update waits upstream.
                        if (bus.rd_valid) begin
                            rd_out_valid_q <= 1'b1;
                            weight_out_q   <= rd_inr ? rd_weight : '0;
                            addr_err_q     <= !rd_inr;
                        end else if (bus.stdp_valid) begin
                            if (st_inr) begin
                                rmw_widx_q  <= PTR_W'(bus.stdp_addr / PER_WORD_A);
                                rmw_lane_q  <= LANE_W'(bus.stdp_addr % PER_WORD_A);
                                rmw_delta_q <= bus.stdp_delta;
                                state_q     <= S_RMW_RD;
                            end else begin
                                addr_err_q  <= 1'b1;
                            end
                        end
                    end
                    S_RMW_RD: begin
                        rmw_word_q <= mem_q[rmw_widx_q];
                        state_q    <= S_RMW_WR;
                    end
                    S_RMW_WR: begin
                        if (sat && sat_count_q != 16'hFFFF) begin
                            sat_count_q <= sat_count_q + 16'd1;
                        end
                        state_q <= S_RUN;
                    end
                    default: state_q <= S_LOAD;
                endcase
            end
        end
    end

    assign bus.load_ready   = load_ready_q;
    assign bus.load_done    = load_done_q;
    assign bus.rd_ready     = run;
    assign bus.stdp_ready   = run && !bus.rd_valid;
    assign bus.rd_out_valid = rd_out_valid_q;
    assign bus.weight_out   = weight_out_q;
    assign bus.addr_err     = addr_err_q;
    assign bus.sat_count    = sat_count_q;
endmodule

// File: doc/synapse_weight_bank.md
Name: synapse_weight_bank

Overview:
Parametrised synaptic weight store for a spiking neuron core. Packs PER_WORD = DATA_W/W_BITS unsigned weights per memory word. Has an explicit bulk-load phase with a valid/ready handshake, then a run phase. In run phase it serves single-weight reads and applies STDP updates as saturating read-modify-writes.
Sits between the config/decoder path (bulk load) and the neuron/learning units (read, STDP).

Parameters:
W_BITS, 8, weight width in bits (unsigned).
DATA_W, 32, memory word and load-data width; must be a multiple of W_BITS.
N_SYN, 128, number of synapses; must be a multiple of PER_WORD.
ADDR_W, 16, synapse address width.
DELTA_W, 8, STDP delta width (two's complement).
Derived: PER_WORD = DATA_W/W_BITS; DEPTH = N_SYN/PER_WORD.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
kill  in  1  synchronous return to load phase
load_valid  in  1  load word present
load_data  in  DATA_W  packed weights; lane 0 = bits [W_BITS-1:0]
load_ready  out  1  accepting load words
load_done  out  1  all DEPTH words loaded; run phase active
rd_valid  in  1  read request
rd_addr  in  ADDR_W  synapse index
rd_ready  out  1  read accepted this cycle when high with rd_valid
rd_out_valid  out  1  weight_out valid (1-cycle pulse)
weight_out  out  W_BITS  read weight
stdp_valid  in  1  update request
stdp_addr  in  ADDR_W  synapse index
stdp_delta  in  DELTA_W  signed delta
stdp_ready  out  1  update accepted when high with stdp_valid
addr_err  out  1  1-cycle pulse on an out-of-range access
sat_count  out  16  count of saturated STDP results; sticks at 0xFFFF

Behaviour:
- Reset (rst low, async): state=LOAD, load pointer=0. All outputs 0 except load_ready=1. Memory contents undefined and not cleared.
- States: LOAD, RUN, RMW_RD, RMW_WR.
- LOAD:
  - load_ready=1.
  - On load_valid: word[ptr] <= load_data; ptr++.
  - On the DEPTH-th accept: go to RUN; load_ready=0 and load_done=1 from the next cycle.
  - rd_valid and stdp_valid are ignored (rd_ready and stdp_ready are 0).
- RUN:
  - rd_ready=1. stdp_ready = !rd_valid, so a read wins over a simultaneous update. The update stays pending upstream; stdp_valid must be held until accepted.
- Read:
  - Accepted at cycle T. At T+1: rd_out_valid=1 and weight_out = lane (rd_addr mod PER_WORD) of word (rd_addr / PER_WORD).
  - Back-to-back reads every cycle are supported.
  - weight_out holds its value between reads.
- STDP:
  - Accept at T moves to RMW_RD. At T+1 the word is latched and the state moves to RMW_WR. At T+2 the modified word is written back. RUN resumes at T+3.
  - rd_ready and stdp_ready are 0 in RMW states.
  - Result = clamp(weight + sign-extended delta, 0, 2^W_BITS-1). Compute at W_BITS+2 bits before clamping.
  - On a clamp, sat_count increments (saturating).
  - Other lanes of the word are unchanged.
- Address range: any rd_addr or stdp_addr >= N_SYN is out of range.
  - Read: rd_out_valid=1, weight_out=0, addr_err pulses.
  - STDP: accepted, no write, addr_err pulses, state stays RUN.
- kill:
  - In any state: next cycle state=LOAD, ptr=0, load_done=0, load_ready=1.
  - An RMW in progress is abandoned with no write. rd_out_valid is suppressed.
  - sat_count is cleared. Memory contents are retained but must be reloaded.
- Async reset mid-RMW: abandoned; same state as power-on reset.
- Read after STDP to the same address always returns the updated value, because RMW completes before RUN resumes.

Test Plan:
1. Defaults (DEPTH=32). Load 32 words, word k lanes = {4k+3,4k+2,4k+1,4k} -> load_done=1 after the 32nd accept. Read addr 5 -> weight_out=5 one cycle later. Read addr 127 -> 127.
2. After test 1, STDP addr 10, delta +20 -> stdp_ready low for 2 cycles. Then read 10=30; reads of 8, 9, 11 = 8, 9, 11.
3. STDP addr 127 delta +127 twice -> 254, then 255 with sat_count=1. STDP addr 3 delta -128 -> 0 with sat_count=2.
4. rd_valid(addr 2) and stdp_valid(addr 2, +1) in the same cycle -> read returns 2, stdp_ready=0. Update accepted the next cycle. A following read returns 3.
5. Read addr 200 -> rd_out_valid=1, weight_out=0, addr_err pulse. STDP addr 128 -> addr_err pulse, no memory change (spot-check addr 0..127).
6. kill after 10 load words -> load_ready=1, ptr restarts; 32 new words are required for load_done. Assert rst during RMW_WR -> target weight unchanged after reload of identical data.
